mem_arbiter: RTL and testbench

Shares one single-ported, variable-latency unified memory between the pipelined core's fetch port (F stage) and its data port (M stage). It runs a req/ack transaction FSM with data-over-fetch priority and holds results in a PC-tagged instruction buffer and a one-entry data buffer. It drives a global `stall` into the core's hazard logic. It sits between `mips` and the memory, in place of separate instruction and data memories.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   arb_state_t  : transaction FSM states
//   AW_DEFAULT   : default address width
//   DW_DEFAULT   : default data width
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_IFETCH = 2'd1,
      ARB_DACC   = 2'd2
   } arb_state_t;

   localparam int AW_DEFAULT = 32;
   localparam int DW_DEFAULT = 32;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the core's
// fetch port and its data port. Data accesses win over fetches. Fetch
// results sit in a PC-tagged instruction buffer; load results sit in a
// one-entry data buffer that empties when the M-stage instruction retires.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pcF / instrF        : fetch address in, buffered instruction out
//   dreqM, memwriteM    : M-stage access present, store(1)/load(0)
//   aluoutM, writedataM : data address and store data
//   readdataM           : buffered load result
//   stall               : freezes the whole pipeline
//   mem_req/we/addr/wdata, mem_rdata, mem_ack : memory transaction port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pcF,
   output logic [DW-1:0] instrF,
   input  logic          dreqM,
   input  logic          memwriteM,
   input  logic [AW-1:0] aluoutM,
   input  logic [DW-1:0] writedataM,
   output logic [DW-1:0] readdataM,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   arb_state_t    r_state,      w_state_next;
   logic          r_ibuf_valid, w_ibuf_valid_next;
   logic [AW-1:0] r_ibuf_pc,    w_ibuf_pc_next;
   logic [DW-1:0] r_ibuf_data,  w_ibuf_data_next;
   logic          r_dbuf_valid, w_dbuf_valid_next;
   logic [DW-1:0] r_dbuf_data,  w_dbuf_data_next;
   logic [AW-1:0] r_lat_addr,   w_lat_addr_next;
   logic          r_lat_we,     w_lat_we_next;
   logic [DW-1:0] r_lat_wdata,  w_lat_wdata_next;
   logic          r_mem_req;

   logic          w_ihit;
   logic          w_dmiss;
   logic          w_stall;

   // A stale ibuf (e.g. filled by a fetch that a redirect overtook) simply
   // misses on the tag compare, so no explicit invalidate is ever needed.
   assign w_ihit  = r_ibuf_valid && (r_ibuf_pc == pcF);
   assign w_dmiss = dreqM && !r_dbuf_valid;
   assign w_stall = !w_ihit || w_dmiss;

   assign stall     = w_stall;
   assign instrF    = r_ibuf_data;
   assign readdataM = r_dbuf_data;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_lat_we;
   assign mem_addr  = r_lat_addr;
   assign mem_wdata = r_lat_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ARB_IDLE;
         r_ibuf_valid <= 1'b0;
         r_ibuf_pc    <= '0;
         r_ibuf_data  <= '0;
         r_dbuf_valid <= 1'b0;
         r_dbuf_data  <= '0;
         r_lat_addr   <= '0;
         r_lat_we     <= 1'b0;
         r_lat_wdata  <= '0;
         r_mem_req    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ibuf_valid <= w_ibuf_valid_next;
         r_ibuf_pc    <= w_ibuf_pc_next;
         r_ibuf_data  <= w_ibuf_data_next;
         r_dbuf_valid <= w_dbuf_valid_next;
         r_dbuf_data  <= w_dbuf_data_next;
         r_lat_addr   <= w_lat_addr_next;
         r_lat_we     <= w_lat_we_next;
         r_lat_wdata  <= w_lat_wdata_next;
         // Request is high exactly while a transaction is outstanding.
         r_mem_req    <= (w_state_next != ARB_IDLE);
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_ibuf_valid_next = r_ibuf_valid;
      w_ibuf_pc_next    = r_ibuf_pc;
      w_ibuf_data_next  = r_ibuf_data;
      w_dbuf_valid_next = r_dbuf_valid;
      w_dbuf_data_next  = r_dbuf_data;
      w_lat_addr_next   = r_lat_addr;
      w_lat_we_next     = r_lat_we;
      w_lat_wdata_next  = r_lat_wdata;

      // An unstalled cycle retires the M-stage instruction, consuming its
      // buffered result so the next memory op must go to memory again.
      if (!w_stall) begin
         w_dbuf_valid_next = 1'b0;
      end

      case (r_state)
         ARB_IDLE: begin
            // mem_ack is ignored here: it can only be a leftover from a
            // transaction cut short by reset.
            if (w_dmiss) begin
               w_state_next     = ARB_DACC;
               w_lat_addr_next  = aluoutM;
               w_lat_we_next    = memwriteM;
               w_lat_wdata_next = writedataM;
            end else if (!w_ihit) begin
               w_state_next    = ARB_IFETCH;
               w_lat_addr_next = pcF;
               w_lat_we_next   = 1'b0;
            end
         end
         ARB_IFETCH: begin
            if (mem_ack) begin
               w_state_next      = ARB_IDLE;
               w_ibuf_valid_next = 1'b1;
               w_ibuf_pc_next    = r_lat_addr;
               w_ibuf_data_next  = mem_rdata;
            end
         end
         ARB_DACC: begin
            // Stores also mark the buffer valid so the pipeline can advance;
            // the captured data is meaningless for them.
            if (mem_ack) begin
               w_state_next      = ARB_IDLE;
               w_dbuf_valid_next = 1'b1;
               w_dbuf_data_next  = mem_rdata;
            end
         end
         default: begin
            w_state_next = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural memory answers
// requests after a programmable number of wait states; every expected
// transaction and every expected buffered word is queued as the stimulus is
// driven and compared when the memory accepts it or the pipeline unstalls.
module tb_mem_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcF;
   logic [31:0] instrF;
   logic        dreqM;
   logic        memwriteM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   // Responder-driven and bench-forced memory replies, selected by auto_mem.
   logic        auto_mem = 1'b1;
   logic        a_ack    = 1'b0;
   logic [31:0] a_rdata  = '0;
   logic        f_ack    = 1'b0;
   logic [31:0] f_rdata  = '0;
   assign mem_ack   = auto_mem ? a_ack   : f_ack;
   assign mem_rdata = auto_mem ? a_rdata : f_rdata;

   logic [31:0] mem [0:63];
   txn_t        txn_q[$];
   logic [31:0] data_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int wait_states = 0;
   int req_cycles  = 0;
   int b2b         = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .pcF        (pcF),
      .instrF     (instrF),
      .dreqM      (dreqM),
      .memwriteM  (memwriteM),
      .aluoutM    (aluoutM),
      .writedataM (writedataM),
      .readdataM  (readdataM),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %s: got %h expected %h ok", tag, got, exp);
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory responder, acting on the falling edge so the reply is stable
   // well before the DUT samples it.
   int          cnt = 0;
   bit          prev_ack = 0;
   bit          unstable = 0;
   logic [31:0] h_addr, h_wdata;
   logic        h_we;
   always @(negedge clk) begin
      if (auto_mem) begin
         if (mem_req) begin
            req_cycles++;
            if (prev_ack) b2b++;
            if (cnt == 0) begin
               h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata; unstable = 0;
            end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
               unstable = 1;
            end
            if (cnt >= wait_states) begin
               txn_t t;
               a_ack   = 1'b1;
               a_rdata = mem[mem_addr[7:2]];
               if (txn_q.size() == 0) begin
                  check_val("txn_unexpected", {31'd0, mem_req}, 32'd0);
               end else begin
                  t = txn_q.pop_front();
                  check_val("txn_addr", mem_addr, t.addr);
                  check_val("txn_we", {31'd0, mem_we}, {31'd0, t.we});
                  if (t.we) check_val("txn_wdata", mem_wdata, t.wdata);
               end
               check_val("txn_hold", {31'd0, unstable}, 32'd0);
               if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
               cnt = 0;
               prev_ack = 1;
            end else begin
               a_ack = 1'b0;
               cnt++;
               prev_ack = 0;
            end
         end else begin
            a_ack = 1'b0;
            cnt = 0;
            prev_ack = 0;
         end
      end else begin
         a_ack = 1'b0;
         cnt = 0;
         prev_ack = 0;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Counts stalled cycles starting with the current one (inputs already driven).
   task automatic count_stall(input int max, output int n);
      #1;
      n = 0;
      while (stall && n < max) begin
         n++;
         step();
      end
   endtask

   task automatic push_txn(input logic [31:0] a, input logic we, input logic [31:0] wd);
      txn_t t;
      t.addr = a; t.we = we; t.wdata = wd;
      txn_q.push_back(t);
   endtask

   int n;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | (i << 2);
      mem[0] = 32'h20080005;

      reset = 1'b1; pcF = 32'h0; dreqM = 1'b0; memwriteM = 1'b0;
      aluoutM = '0; writedataM = '0;
      step(); step();

      // Reset state
      check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_val("rst_stall", {31'd0, stall}, 32'd1);
      check_val("rst_instrF", instrF, 32'd0);
      check_val("rst_readdataM", readdataM, 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);

      // First fetch, zero-wait memory
      wait_states = 0; req_cycles = 0;
      push_txn(32'h00, 1'b0, 32'h0);
      data_q.push_back(32'h20080005);
      reset = 1'b0;
      count_stall(50, n);
      check_val("fetch0_stall_cycles", n, 2);
      check_val("fetch0_req_cycles", req_cycles, 1);
      check_val("fetch0_instrF", instrF, data_q.pop_front());

      // Load with three wait states while fetch hits
      wait_states = 3; req_cycles = 0;
      push_txn(32'h40, 1'b0, 32'h0);
      data_q.push_back(mem[16]);
      dreqM = 1'b1; memwriteM = 1'b0; aluoutM = 32'h40;
      count_stall(50, n);
      check_val("load_stall_cycles", n, 5);
      check_val("load_readdataM", readdataM, data_q.pop_front());
      step();
      check_val("load_dbuf_cleared", {31'd0, stall}, 32'd1);
      dreqM = 1'b0;
      #1;
      check_val("load_unstall_after_drop", {31'd0, stall}, 32'd0);
      check_val("load_req_cycles", req_cycles, 4);

      // Store with a simultaneous fetch miss: data first, then fetch
      wait_states = 0; req_cycles = 0; b2b = 0;
      push_txn(32'h54, 1'b1, 32'hDEADBEEF);
      push_txn(32'h08, 1'b0, 32'h0);
      data_q.push_back(mem[2]);
      pcF = 32'h08; dreqM = 1'b1; memwriteM = 1'b1;
      aluoutM = 32'h54; writedataM = 32'hDEADBEEF;
      count_stall(50, n);
      check_val("store_stall_cycles", n, 4);
      check_val("store_req_cycles", req_cycles, 2);
      check_val("store_req_gap", b2b, 0);
      check_val("store_instrF", instrF, data_q.pop_front());
      dreqM = 1'b0; memwriteM = 1'b0; writedataM = '0;
      step();

      // Read back the stored word
      wait_states = 1; req_cycles = 0;
      push_txn(32'h54, 1'b0, 32'h0);
      data_q.push_back(32'hDEADBEEF);
      dreqM = 1'b1; aluoutM = 32'h54;
      count_stall(50, n);
      check_val("readback_stall_cycles", n, 3);
      check_val("readback_data", readdataM, data_q.pop_front());
      dreqM = 1'b0;
      step();

      // Redirect while a fetch is in flight
      wait_states = 2; req_cycles = 0;
      push_txn(32'h0C, 1'b0, 32'h0);
      push_txn(32'h30, 1'b0, 32'h0);
      data_q.push_back(mem[12]);
      pcF = 32'h0C;
      step();
      check_val("redir_req_issued", {31'd0, mem_req}, 32'd1);
      pcF = 32'h30;
      count_stall(50, n);
      check_val("redir_stall_cycles", n, 7);
      check_val("redir_req_cycles", req_cycles, 6);
      check_val("redir_instrF", instrF, data_q.pop_front());

      // Reset in the second wait cycle of a load, then a late ack
      auto_mem = 1'b0; f_ack = 1'b0;
      dreqM = 1'b1; memwriteM = 1'b0; aluoutM = 32'h20;
      step();
      step();
      check_val("mid_dacc_req", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      step();
      check_val("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_val("mid_rst_stall", {31'd0, stall}, 32'd1);
      check_val("mid_rst_readdataM", readdataM, 32'd0);
      check_val("mid_rst_instrF", instrF, 32'd0);
      check_val("mid_rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b0; dreqM = 1'b0; pcF = 32'h04; aluoutM = '0;
      f_ack = 1'b1; f_rdata = 32'h12345678;
      step();
      f_ack = 1'b0;
      check_val("late_ack_readdataM", readdataM, 32'd0);
      check_val("late_ack_fetch_req", {31'd0, mem_req}, 32'd1);
      check_val("late_ack_fetch_addr", mem_addr, 32'h04);
      push_txn(32'h04, 1'b0, 32'h0);
      data_q.push_back(mem[1]);
      wait_states = 0;
      auto_mem = 1'b1;
      count_stall(50, n);
      check_val("post_rst_stall_cycles", n, 2);
      check_val("post_rst_instrF", instrF, data_q.pop_front());
      check_val("post_rst_readdataM", readdataM, 32'd0);

      step();
      check_val("txn_queue_drained", txn_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
